// File: rtl/msp_sr_pkg.sv
// rtl/msp_sr_pkg.sv - shared SR bit positions, entry clear mask and stack-op encoding
package msp_sr_pkg;

    // SR bit positions
    localparam int SR_C      = 0;
    localparam int SR_Z      = 1;
    localparam int SR_N      = 2;
    localparam int SR_GIE    = 3;
    localparam int SR_CPUOFF = 4;
    localparam int SR_OSCOFF = 5;
    localparam int SR_SCG0   = 6;
    localparam int SR_SCG1   = 7;
    localparam int SR_V      = 8;

    // Interrupt entry disables interrupts and wakes the CPU and clocks
    localparam logic [15:0] SR_ENTRY_CLR = (16'h1 << SR_GIE)  | (16'h1 << SR_CPUOFF) |
                                           (16'h1 << SR_OSCOFF) | (16'h1 << SR_SCG0) |
                                           (16'h1 << SR_SCG1);

    typedef enum logic [1:0] {
        SOP_NONE,
        SOP_PUSH,
        SOP_POP,
        SOP_COLL
    } stack_op_e;

    // Collapse the raw push/pop requests into one stack operation
    function automatic stack_op_e decode_stack_op(input logic push, input logic pop);
        if (push && pop) return SOP_COLL;
        if (pop)         return SOP_POP;
        if (push)        return SOP_PUSH;
        return SOP_NONE;
    endfunction

endpackage

// File: rtl/sr_ctrl_stack_if.sv
// rtl/sr_ctrl_stack_if.sv - decoder/execution side bus of the SR control unit
interface sr_ctrl_stack_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 2
);
    localparam int SW = $clog2(NUM_SRC);

    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SW-1:0]            src_sel;
    logic                     wr_en;
    logic [WIDTH-1:0]         wr_mask;
    logic                     push;
    logic                     pop;
    logic [WIDTH-1:0]         sr_q;
    logic [WIDTH-1:0]         sr_d;
    logic                     stk_empty;
    logic                     stk_full;
    logic                     err;

    modport master (
        output src_data, src_sel, wr_en, wr_mask, push, pop,
        input  sr_q, sr_d, stk_empty, stk_full, err
    );

    modport slave (
        input  src_data, src_sel, wr_en, wr_mask, push, pop,
        output sr_q, sr_d, stk_empty, stk_full, err
    );

endinterface

// File: rtl/sr_shadow_stack.sv
// rtl/sr_shadow_stack.sv - LIFO shadow stack holding SR values saved on interrupt entry
module sr_shadow_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign top_idx = count_q[AW-1:0] - AW'(1);
    assign rdata_o = mem[top_idx];

    // Saturating up/down count; requests that would over/underflow are dropped
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i && !full_o) begin
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i && !empty_o) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register; reset discards every saved entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push_i && !pop_i && !full_o) begin
            mem[count_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/sr_ctrl_stack.sv
// rtl/sr_ctrl_stack.sv - SR source select, masked write, interrupt push/RETI pop and error flag
module sr_ctrl_stack
    import msp_sr_pkg::*;
#(
    parameter int               WIDTH          = 16,
    parameter int               NUM_SRC        = 2,
    parameter int               DEPTH          = 4,
    parameter logic [WIDTH-1:0] ENTRY_CLR_MASK = WIDTH'(SR_ENTRY_CLR)
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_ctrl_stack_if.slave bus
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] sel_src;
    logic [WIDTH-1:0] wval;
    logic [WIDTH-1:0] base_val;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full;
    logic             stk_empty;
    stack_op_e        sop;

    // Source mux; any out-of-range index falls back to source 0
    always_comb begin
        sel_src = bus.src_data[WIDTH-1:0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (int'(bus.src_sel) == i) begin
                sel_src = bus.src_data[WIDTH*i +: WIDTH];
            end
        end
    end

    assign wval     = (sr_q & ~bus.wr_mask) | (sel_src & bus.wr_mask);
    assign base_val = bus.wr_en ? wval : sr_q;
    assign sop      = decode_stack_op(bus.push, bus.pop);

    // Priority resolution: RETI owns SR on a successful pop, entry clears mode bits
    always_comb begin
        sr_d     = base_val;
        err_d    = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        case (sop)
            SOP_COLL: begin
                err_d = 1'b1;
            end
            SOP_POP: begin
                if (!stk_empty) begin
                    sr_d    = stk_top;
                    stk_pop = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            SOP_PUSH: begin
                sr_d = base_val & ~ENTRY_CLR_MASK;
                if (!stk_full) begin
                    stk_push = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                sr_d = base_val;
            end
        endcase
    end

    // SR and error-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            err_q <= err_d;
        end
    end

    // The stack captures the pre-write SR so RETI returns the interrupted context
    sr_shadow_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .wdata_i (sr_q),
        .rdata_o (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign bus.sr_q      = sr_q;
    assign bus.sr_d      = sr_d;
    assign bus.err       = err_q;
    assign bus.stk_empty = stk_empty;
    assign bus.stk_full  = stk_full;

endmodule
